// File: rtl/banco_regs_pkg.sv
// Shared op-code definitions for the banco_regs register bank and its
// combinational operation unit.
package banco_regs_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_HOLD  = 3'd0;
  localparam op_t OP_CLEAR = 3'd1;
  localparam op_t OP_LOAD  = 3'd2;
  localparam op_t OP_INC   = 3'd3;
  localparam op_t OP_DEC   = 3'd4;
  localparam op_t OP_SHL   = 3'd5;
  localparam op_t OP_SHR   = 3'd6;
  localparam op_t OP_RSVD  = 3'd7;

endpackage

// File: rtl/banco_regs_op_unit.sv
// Combinational datapath: computes the write-back value and would-be flags
// for one register-level operation.
module reg_op_unit
  import banco_regs_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] barramento,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             zero_n,
  output logic             carry_n,
  output logic             exec
);

  logic [WIDTH:0] sum;

  // NOTE: every output gets a default before the case, so no path through
  // this block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    result  = r;
    carry_n = 1'b0;
    exec    = 1'b1;
    sum     = {1'b0, r} + {{WIDTH{1'b0}}, 1'b1};
    unique case (op_t'(op))
      OP_CLEAR: result = '0;
      OP_LOAD:  result = barramento;
      OP_INC: begin
        result  = sum[WIDTH-1:0];
        carry_n = sum[WIDTH];
      end
      OP_DEC: begin
        result  = r - {{(WIDTH-1){1'b0}}, 1'b1};
        carry_n = (r == '0);
      end
      OP_SHL: begin
        result  = {r[WIDTH-2:0], 1'b0};
        carry_n = r[WIDTH-1];
      end
      OP_SHR: begin
        result  = {1'b0, r[WIDTH-1:1]};
        carry_n = r[0];
      end
      default: exec = 1'b0;
    endcase
    zero_n = (result == '0);
  end

endmodule

// File: rtl/banco_regs.sv
// Parametrised register bank: one read-modify-write op per cycle on a
// selected register, two forwarded registered read ports, zero/carry flags.
module banco_regs
  import banco_regs_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int NREGS  = 4,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [WIDTH-1:0]  barramento,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] sel_w,
  input  logic [ADDR_W-1:0] sel_a,
  input  logic [ADDR_W-1:0] sel_b,
  output logic [WIDTH-1:0]  a,
  output logic [WIDTH-1:0]  b,
  output logic              zero,
  output logic              carry
);

  localparam logic [ADDR_W:0] NREGS_L = (ADDR_W + 1)'(NREGS);

  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] r_cur;
  logic [WIDTH-1:0] result;
  logic             zero_n;
  logic             carry_n;
  logic             exec;
  logic             w_ok;
  logic             a_ok;
  logic             b_ok;
  logic             do_write;
  logic [WIDTH-1:0] a_next;
  logic [WIDTH-1:0] b_next;

  assign w_ok     = ({1'b0, sel_w} < NREGS_L);
  assign a_ok     = ({1'b0, sel_a} < NREGS_L);
  assign b_ok     = ({1'b0, sel_b} < NREGS_L);
  assign r_cur    = w_ok ? regs[sel_w] : '0;
  assign do_write = exec && w_ok;

  reg_op_unit #(.WIDTH(WIDTH)) u_op (
    .r          (r_cur),
    .barramento (barramento),
    .op         (op),
    .result     (result),
    .zero_n     (zero_n),
    .carry_n    (carry_n),
    .exec       (exec)
  );

  // Write-first: a port selecting the register being written sees the new value.
  always_comb begin
    a_next = '0;
    b_next = '0;
    if (a_ok) a_next = (do_write && sel_a == sel_w) ? result : regs[sel_a];
    if (b_ok) b_next = (do_write && sel_b == sel_w) ? result : regs[sel_b];
  end

  // NOTE: the bank is a handful of flops, not a RAM macro, so clearing every
  // entry in reset is cheap and gives a defined power-up state.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (do_write) begin
      regs[sel_w] <= result;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      a     <= '0;
      b     <= '0;
      zero  <= 1'b0;
      carry <= 1'b0;
    end else begin
      a <= a_next;
      b <= b_next;
      if (do_write) begin
        zero  <= zero_n;
        carry <= carry_n;
      end
    end
  end

endmodule

// File: tb/tb_banco_regs.sv
// Scoreboard bench: drives a 4-register and a 3-register bank in parallel and
// compares both against an arithmetic reference model.
module tb_banco_regs;

  typedef struct {
    int         k;
    logic [3:0] a;
    logic [3:0] b;
    logic       z;
    logic       c;
    int         cyc;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] barramento = '0;
  logic [2:0] op = '0;
  logic [1:0] sel_w = '0;
  logic [1:0] sel_a = '0;
  logic [1:0] sel_b = '0;

  logic [3:0] a4, b4, a3, b3;
  logic       z4, c4, z3, c3;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  exp_t q[$];

  int m_regs [2][4];
  bit m_z [2];
  bit m_c [2];

  always #5 clock = ~clock;

  banco_regs #(.WIDTH(4), .NREGS(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .barramento(barramento), .op(op),
    .sel_w(sel_w), .sel_a(sel_a), .sel_b(sel_b),
    .a(a4), .b(b4), .zero(z4), .carry(c4)
  );

  banco_regs #(.WIDTH(4), .NREGS(3)) dut3 (
    .clock(clock), .reset_n(reset_n), .barramento(barramento), .op(op),
    .sel_w(sel_w), .sel_a(sel_a), .sel_b(sel_b),
    .a(a3), .b(b3), .zero(z3), .carry(c3)
  );

  task automatic check(input string name, input int k, input int c_no,
                       input logic [3:0] got, input logic [3:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s dut_nregs%0d cycle %0d: got %h expected %h",
               name, (k == 0) ? 4 : 3, c_no, got, want);
    end
  endtask

  // Reference model: plain integer arithmetic on the register contents.
  task automatic model_step(input int k, input bit rn, input int o,
                            input int sw, input int sa, input int sb, input int bus);
    int   nr;
    int   r;
    int   res;
    bit   cy;
    exp_t e;
    nr = (k == 0) ? 4 : 3;
    if (!rn) begin
      for (int i = 0; i < 4; i++) m_regs[k][i] = 0;
      m_z[k] = 0;
      m_c[k] = 0;
    end else if (o >= 1 && o <= 6 && sw < nr) begin
      r  = m_regs[k][sw];
      cy = 0;
      case (o)
        1: res = 0;
        2: res = bus;
        3: begin res = (r + 1) % 16;  cy = (r == 15); end
        4: begin res = (r + 15) % 16; cy = (r == 0);  end
        5: begin res = (r * 2) % 16;  cy = (r >= 8);  end
        default: begin res = r / 2;   cy = (r % 2 == 1); end
      endcase
      m_regs[k][sw] = res;
      m_z[k] = (res == 0);
      m_c[k] = cy;
    end
    e.k   = k;
    e.a   = (rn && sa < nr) ? 4'(m_regs[k][sa]) : 4'h0;
    e.b   = (rn && sb < nr) ? 4'(m_regs[k][sb]) : 4'h0;
    e.z   = m_z[k];
    e.c   = m_c[k];
    e.cyc = cyc;
    q.push_back(e);
  endtask

  task automatic cycle(input bit rn, input int o, input int sw, input int sa,
                       input int sb, input int bus);
    @(negedge clock);
    reset_n    = rn;
    op         = 3'(o);
    sel_w      = 2'(sw);
    sel_a      = 2'(sa);
    sel_b      = 2'(sb);
    barramento = 4'(bus);
    @(posedge clock);
    cyc++;
    model_step(0, rn, o, sw, sa, sb, bus);
    model_step(1, rn, o, sw, sa, sb, bus);
  endtask

  always @(negedge clock) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.k == 0) begin
        check("a", 0, e.cyc, a4, e.a);
        check("b", 0, e.cyc, b4, e.b);
        check("zero", 0, e.cyc, {3'b0, z4}, {3'b0, e.z});
        check("carry", 0, e.cyc, {3'b0, c4}, {3'b0, e.c});
      end else begin
        check("a", 1, e.cyc, a3, e.a);
        check("b", 1, e.cyc, b3, e.b);
        check("zero", 1, e.cyc, {3'b0, z3}, {3'b0, e.z});
        check("carry", 1, e.cyc, {3'b0, c3}, {3'b0, e.c});
      end
    end
  end

  initial begin
    // reset, preload 5 everywhere, then reset while a LOAD is presented
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cycle(1, 2, i, i, 0, 5);
    cycle(0, 2, 0, 0, 1, 9);
    cycle(1, 0, 0, 2, 3, 9);
    // forwarding on LOAD
    cycle(1, 2, 2, 2, 1, 10);
    // wrap arithmetic
    cycle(1, 2, 1, 1, 0, 15);
    cycle(1, 3, 1, 1, 2, 0);
    cycle(1, 4, 3, 3, 1, 0);
    // shifts, then HOLD and reserved keep flags
    cycle(1, 2, 0, 0, 3, 9);
    cycle(1, 5, 0, 0, 3, 0);
    cycle(1, 6, 0, 0, 3, 0);
    cycle(1, 0, 0, 0, 3, 0);
    cycle(1, 7, 0, 0, 2, 0);
    // out-of-range write/read on the 3-register bank
    cycle(1, 2, 3, 3, 2, 7);
    cycle(1, 3, 3, 3, 3, 0);
    // reset in the middle of a run of INCs
    cycle(1, 3, 0, 0, 0, 0);
    cycle(1, 3, 0, 0, 0, 0);
    cycle(0, 3, 0, 0, 0, 0);
    cycle(1, 3, 0, 0, 1, 0);
    // randomized traffic
    for (int i = 0; i < 500; i++)
      cycle($urandom_range(0, 29) != 0, $urandom_range(0, 7), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 15));
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clock);
    #1;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
